// File: rtl/cond_unit_pipe.sv
// Execute-stage condition unit with banked NZCV flags and registered M-stage enables.
// Each flag bank holds its own state; the selected bank is evaluated, updated and exposed.
module cond_unit_pipe #(
  parameter int NUM_BANKS = 2,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush_e,
  input  logic [3:0]    cond_e,
  input  logic [3:0]    alu_flags_e,
  input  logic [1:0]    flag_w_e,
  input  logic          pcs_e,
  input  logic          reg_w_e,
  input  logic          mem_w_e,
  input  logic          no_write_e,
  input  logic [BW-1:0] bank_sel_e,
  input  logic          copy_e,
  input  logic [BW-1:0] copy_src_e,
  output logic          cond_ex_e,
  output logic          pc_src_e,
  output logic [3:0]    flags_o,
  output logic          pc_src_m,
  output logic          reg_write_m,
  output logic          mem_write_m
);

  logic [NUM_BANKS-1:0][3:0] bank_flags;
  logic [NUM_BANKS-1:0]      sel_hit;
  logic [NUM_BANKS-1:0]      src_hit;
  logic [3:0]                cur_flags;
  logic [3:0]                src_flags;
  logic [3:0]                base_flags;
  logic [3:0]                new_flags;
  logic                      sel_valid;
  logic                      src_valid;
  logic                      cond_raw;
  logic                      bank_we;
  logic                      n, z, c, v;

  // One-hot decode; an out-of-range select hits no bank and reads as 0000.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
      assign sel_hit[gi] = (bank_sel_e == BW'(gi));
      assign src_hit[gi] = (copy_src_e == BW'(gi));
    end
  endgenerate

  assign sel_valid = |sel_hit;
  assign src_valid = |src_hit;

  always_comb begin
    cur_flags = 4'b0000;
    src_flags = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cur_flags = cur_flags | (bank_flags[i] & {4{sel_hit[i]}});
      src_flags = src_flags | (bank_flags[i] & {4{src_hit[i]}});
    end
  end

  assign {n, z, c, v} = cur_flags;
  assign flags_o      = cur_flags;

  always_comb begin
    cond_raw = 1'b0;
    case (cond_e)
      4'd0:    cond_raw = z;
      4'd1:    cond_raw = ~z;
      4'd2:    cond_raw = c;
      4'd3:    cond_raw = ~c;
      4'd4:    cond_raw = n;
      4'd5:    cond_raw = ~n;
      4'd6:    cond_raw = v;
      4'd7:    cond_raw = ~v;
      4'd8:    cond_raw = c & ~z;
      4'd9:    cond_raw = ~c | z;
      4'd10:   cond_raw = (n == v);
      4'd11:   cond_raw = (n != v);
      4'd12:   cond_raw = ~z & (n == v);
      4'd13:   cond_raw = z | (n != v);
      default: cond_raw = 1'b1;
    endcase
  end

  assign cond_ex_e = cond_raw & ~flush_e;
  assign pc_src_e  = cond_ex_e & pcs_e;

  // Copy (if any) forms the base, then each enabled flag group is overlaid.
  assign base_flags = copy_e ? src_flags : cur_flags;
  assign new_flags  = {flag_w_e[1] ? alu_flags_e[3:2] : base_flags[3:2],
                       flag_w_e[0] ? alu_flags_e[1:0] : base_flags[1:0]};
  assign bank_we    = cond_ex_e & ~stall & sel_valid & (~copy_e | src_valid);

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [3:0] flags_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          flags_reg <= 4'b0000;
        end else if (bank_we && sel_hit[gi]) begin
          flags_reg <= new_flags;
        end
      end
      assign bank_flags[gi] = flags_reg;
    end
  endgenerate

  // Stall wins over flush: a frozen pipeline keeps whatever M already holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_src_m    <= 1'b0;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
    end else if (!stall) begin
      if (flush_e) begin
        pc_src_m    <= 1'b0;
        reg_write_m <= 1'b0;
        mem_write_m <= 1'b0;
      end else begin
        pc_src_m    <= cond_ex_e & pcs_e;
        reg_write_m <= cond_ex_e & reg_w_e & ~no_write_e;
        mem_write_m <= cond_ex_e & mem_w_e;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed bench for cond_unit_pipe with three banks so out-of-range selects are reachable.
module tb_cond_unit_pipe;

  localparam int NB = 3;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset, stall, flush_e;
  logic [3:0]    cond_e, alu_flags_e;
  logic [1:0]    flag_w_e;
  logic          pcs_e, reg_w_e, mem_w_e, no_write_e, copy_e;
  logic [BW-1:0] bank_sel_e, copy_src_e;
  logic          cond_ex_e, pc_src_e, pc_src_m, reg_write_m, mem_write_m;
  logic [3:0]    flags_o;

  int n_checks = 0;
  int n_fails  = 0;

  cond_unit_pipe #(.NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_e(flush_e),
    .cond_e(cond_e), .alu_flags_e(alu_flags_e), .flag_w_e(flag_w_e),
    .pcs_e(pcs_e), .reg_w_e(reg_w_e), .mem_w_e(mem_w_e), .no_write_e(no_write_e),
    .bank_sel_e(bank_sel_e), .copy_e(copy_e), .copy_src_e(copy_src_e),
    .cond_ex_e(cond_ex_e), .pc_src_e(pc_src_e), .flags_o(flags_o),
    .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush_e = 0; cond_e = 4'd14; alu_flags_e = 4'b0000; flag_w_e = 2'b00;
    pcs_e = 0; reg_w_e = 0; mem_w_e = 0; no_write_e = 0;
    copy_e = 0; copy_src_e = '0; bank_sel_e = '0;
  endtask

  // Load a bank with an AL full-flag write.
  task automatic load_bank(input logic [BW-1:0] sel, input logic [3:0] val);
    idle();
    bank_sel_e = sel; flag_w_e = 2'b11; alu_flags_e = val;
    tick();
    idle();
    bank_sel_e = sel;
    #1;
  endtask

  logic [3:0]  pats [5]  = '{4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b0010};
  logic [15:0] masks [5] = '{16'hD6AA, 16'hE6A9, 16'hEA9A, 16'hD65A, 16'hD5A6};

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    #2 reset = 0;
    #1;
    check("rst_flags", 16'(flags_o), 16'h0);
    check("rst_pc_src_m", 16'(pc_src_m), 16'h0);
    check("rst_reg_write_m", 16'(reg_write_m), 16'h0);
    check("rst_mem_write_m", 16'(mem_write_m), 16'h0);
    cond_e = 4'd0; #1;
    check("rst_eq", 16'(cond_ex_e), 16'h0);
    cond_e = 4'd14; #1;
    check("rst_al", 16'(cond_ex_e), 16'h1);

    // Populate state, then reset asynchronously mid-cycle.
    idle();
    pcs_e = 1; reg_w_e = 1; mem_w_e = 1; flag_w_e = 2'b11; alu_flags_e = 4'b1111;
    tick();
    check("pre_pc_src_m", 16'(pc_src_m), 16'h1);
    check("pre_reg_write_m", 16'(reg_write_m), 16'h1);
    check("pre_mem_write_m", 16'(mem_write_m), 16'h1);
    check("pre_flags", 16'(flags_o), 16'hF);
    idle();
    #2 reset = 1;
    #1;
    check("async_pc_src_m", 16'(pc_src_m), 16'h0);
    check("async_reg_write_m", 16'(reg_write_m), 16'h0);
    check("async_mem_write_m", 16'(mem_write_m), 16'h0);
    check("async_flags", 16'(flags_o), 16'h0);
    #1 reset = 0;

    // Per-group writes on bank 0.
    idle(); flag_w_e = 2'b10; alu_flags_e = 4'b1111;
    tick();
    check("grp_nz", 16'(flags_o), 16'hC);
    flag_w_e = 2'b01; alu_flags_e = 4'b0001;
    tick();
    check("grp_cv", 16'(flags_o), 16'hD);

    // Condition sweep over stored flag patterns.
    for (int p = 0; p < 5; p++) begin
      load_bank('0, pats[p]);
      pcs_e = 1;
      for (int k = 0; k < 16; k++) begin
        cond_e = 4'(k);
        #1;
        check($sformatf("cond_%b_c%0d", pats[p], k), 16'(cond_ex_e), 16'(masks[p][k]));
        check($sformatf("pcsrc_%b_c%0d", pats[p], k), 16'(pc_src_e), 16'(masks[p][k]));
      end
    end

    // Failed condition leaves flags alone and kills the write enable.
    idle(); flag_w_e = 2'b11; alu_flags_e = 4'b0000; reg_w_e = 1;
    tick();
    check("clr_reg_write_m", 16'(reg_write_m), 16'h1);
    cond_e = 4'd0; flag_w_e = 2'b11; alu_flags_e = 4'b1111; reg_w_e = 1;
    tick();
    check("fail_flags", 16'(flags_o), 16'h0);
    check("fail_reg_write_m", 16'(reg_write_m), 16'h0);
    idle(); reg_w_e = 1; no_write_e = 1;
    tick();
    check("nowrite_reg_write_m", 16'(reg_write_m), 16'h0);

    // Banks and copy.
    load_bank(2'd1, 4'b1010);
    check("bank1_write", 16'(flags_o), 16'hA);
    bank_sel_e = 2'd0; #1;
    check("bank0_untouched", 16'(flags_o), 16'h0);
    copy_e = 1; copy_src_e = 2'd1; flag_w_e = 2'b01; alu_flags_e = 4'b0001;
    tick();
    idle(); #1;
    check("copy_overlay", 16'(flags_o), 16'h9);
    bank_sel_e = 2'd1; #1;
    check("copy_src_kept", 16'(flags_o), 16'hA);

    // Out-of-range selects.
    bank_sel_e = 2'd3; #1;
    check("oor_flags", 16'(flags_o), 16'h0);
    cond_e = 4'd0; #1;
    check("oor_eq", 16'(cond_ex_e), 16'h0);
    cond_e = 4'd1; #1;
    check("oor_ne", 16'(cond_ex_e), 16'h1);
    cond_e = 4'd14; flag_w_e = 2'b11; alu_flags_e = 4'b1111;
    tick();
    idle(); #1;
    check("oor_bank0", 16'(flags_o), 16'h9);
    bank_sel_e = 2'd2; #1;
    check("oor_bank2", 16'(flags_o), 16'h0);
    copy_e = 1; copy_src_e = 2'd3; flag_w_e = 2'b11; alu_flags_e = 4'b0110;
    tick();
    idle(); bank_sel_e = 2'd2; #1;
    check("oor_copy_blocked", 16'(flags_o), 16'h0);
    load_bank(2'd2, 4'b0110);
    check("bank2_write", 16'(flags_o), 16'h6);

    // Stall holds M registers and banks.
    idle(); mem_w_e = 1;
    tick();
    check("pre_stall_mem", 16'(mem_write_m), 16'h1);
    stall = 1; mem_w_e = 0; flag_w_e = 2'b11; alu_flags_e = 4'b1111;
    tick();
    check("stall_hold1_mem", 16'(mem_write_m), 16'h1);
    check("stall_flags", 16'(flags_o), 16'h9);
    stall = 0; flag_w_e = 2'b00;
    tick();
    check("unstall_mem", 16'(mem_write_m), 16'h0);
    stall = 1; mem_w_e = 1;
    tick();
    check("stall_hold0_mem", 16'(mem_write_m), 16'h0);

    // Flush squashes evaluation, M load and flag write.
    idle(); mem_w_e = 1;
    tick();
    check("pre_flush_mem", 16'(mem_write_m), 16'h1);
    flush_e = 1; pcs_e = 1; flag_w_e = 2'b11; alu_flags_e = 4'b0000;
    #1;
    check("flush_cond_ex", 16'(cond_ex_e), 16'h0);
    check("flush_pc_src_e", 16'(pc_src_e), 16'h0);
    tick();
    check("flush_mem", 16'(mem_write_m), 16'h0);
    check("flush_flags", 16'(flags_o), 16'h9);

    // Stall and flush together: full freeze.
    idle(); mem_w_e = 1;
    tick();
    stall = 1; flush_e = 1; flag_w_e = 2'b11; alu_flags_e = 4'b0000;
    tick();
    check("both_mem_held", 16'(mem_write_m), 16'h1);
    check("both_flags", 16'(flags_o), 16'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
